// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// ARB_MAX_HOLD is the default forced-release limit used under ARB_TIMEOUT_EN.
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int ID_W         = 3;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin pick: rotate req by ptr,
// take the lowest set bit, then map back to a requester index.
module rr_pick_next
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  win_id,
  output logic [N_REQ-1:0] win_onehot
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    off;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  // Scan downward so the lowest set bit wins.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
  end

  assign any        = |req;
  assign win_id     = ptr + off;
  assign win_onehot = any ? (N_REQ'(1) << win_id) : '0;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
module rr_arbiter_8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t      state;
  logic [ID_W-1:0] ptr;
  logic            any;
  logic [ID_W-1:0] win_id;
  logic [N_REQ-1:0] win_onehot;
  logic            keep;

  rr_pick_next u_pick (
    .req        (req),
    .ptr        (ptr),
    .any        (any),
    .win_id     (win_id),
    .win_onehot (win_onehot)
  );

  assign keep = req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold;
  logic       others;
  logic       expire;

  assign others = |(req & ~gnt);
  assign expire = (hold == HOLD_LAST) && others;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      hold      <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (any) begin
            state     <= ARB_GRANT;
            gnt       <= win_onehot;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold      <= '0;
          end
        end
        ARB_GRANT: begin
          if (!keep || expire) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 1'b1;
            timeout   <= keep;
          end else if (hold != HOLD_LAST) begin
            hold <= hold + 8'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any) begin
            state     <= ARB_GRANT;
            gnt       <= win_onehot;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!keep) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
`endif

endmodule
